ay_kbd_encoder: RTL and testbench

//  Parametrised successor keyboard encoder for the Apple II core. Takes USB boot-protocol key reports

---
 rtl/ay_kbd_pkg.sv | 67 ++++++
 rtl/ay_kbd_keymap.sv | 16 +
 rtl/ay_kbd_encoder.sv | 267 ++++++++++++++++++++++++++
 tb/tb_ay_kbd_encoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ay_kbd_pkg.sv
// Shared types, keycode constants and the USB-keycode to Apple II ASCII map
// for the ay_kbd_encoder keyboard block.
package ay_kbd_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [7:0] ROLLOVER_CODE = 8'h01;
    localparam logic [7:0] KC_A          = 8'h04;
    localparam logic [7:0] KC_Z          = 8'h1D;
    localparam logic [7:0] KC_1          = 8'h1E;
    localparam logic [7:0] KC_9          = 8'h26;
    localparam logic [7:0] KC_0          = 8'h27;
    localparam logic [7:0] KC_ENTER      = 8'h28;
    localparam logic [7:0] KC_ESC        = 8'h29;
    localparam logic [7:0] KC_BKSP       = 8'h2A;
    localparam logic [7:0] KC_TAB        = 8'h2B;
    localparam logic [7:0] KC_SPACE      = 8'h2C;
    localparam logic [7:0] KC_RIGHT      = 8'h4F;
    localparam logic [7:0] KC_LEFT       = 8'h50;
    localparam logic [7:0] KC_DOWN       = 8'h51;
    localparam logic [7:0] KC_UP         = 8'h52;

    localparam logic [7:0] LETTER_OFS    = 8'h3D;  // 0x04 -> 'A'
    localparam logic [7:0] DIGIT_OFS     = 8'h13;  // 0x1E -> '1'

    // Returns {valid, ascii[6:0]}; valid=0 for codes the Apple II has no key for.
    function automatic logic [7:0] KEYMAP(input logic [7:0] code, input logic shift, input logic ctrl);
        logic [7:0] a;
        logic       v;
        a = 8'h00;
        v = 1'b1;
        if (code >= KC_A && code <= KC_Z) begin
            a = code + LETTER_OFS;
            if (ctrl) begin
                a = a & 8'h1F;
            end else begin
                a = a;
            end
        end else if (code >= KC_1 && code <= KC_9) begin
            a = code + DIGIT_OFS;
            if (shift) begin
                a = a - 8'h10;
            end else begin
                a = a;
            end
        end else begin
            case (code)
                KC_0:     a = 8'h30;
                KC_ENTER: a = 8'h0D;
                KC_ESC:   a = 8'h1B;
                KC_BKSP:  a = 8'h7F;
                KC_TAB:   a = 8'h09;
                KC_SPACE: a = 8'h20;
                KC_RIGHT: a = 8'h15;
                KC_LEFT:  a = 8'h08;
                KC_DOWN:  a = 8'h0A;
                KC_UP:    a = 8'h0B;
                default:  v = 1'b0;
            endcase
        end
        return {v, a[6:0]};
    endfunction

endpackage

// File: rtl/ay_kbd_keymap.sv
// Combinational keycode-to-ASCII translator for the slot currently being scanned.
module ay_kbd_keymap
    import ay_kbd_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       ctrl,
    output logic       valid,
    output logic [6:0] ascii
);

    always_comb begin
        {valid, ascii} = KEYMAP(code, shift, ctrl);
    end

endmodule

// File: rtl/ay_kbd_encoder.sv
// Apple II keyboard encoder: detects newly pressed keys in USB boot reports,
// latches their ASCII code with a sticky strobe. Optional auto-repeat under AY_KBD_REPEAT_EN.
module ay_kbd_encoder
    import ay_kbd_pkg::*;
#(
    parameter int NUM_KEYS      = 6,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 2500000
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  report_valid,
    input  logic [8*NUM_KEYS-1:0] keycodes,
    input  logic [7:0]            modifiers,
    input  logic                  kstrb_clr,
    output logic [6:0]            md_out,
    output logic                  kstrb,
    output logic                  akd,
    output logic                  busy
);

    localparam int         KW        = 8 * NUM_KEYS;
    localparam logic [2:0] LAST_SLOT = 3'(NUM_KEYS - 1);

    if (NUM_KEYS < 1 || NUM_KEYS > 8 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_err
        $error("ay_kbd_encoder: illegal parameter value");
    end

    state_t          state_q, state_d;
    logic [KW-1:0]   cur_q, cur_d, prev_q, prev_d, pend_q, pend_d;
    logic            cur_shift_q, cur_shift_d, cur_ctrl_q, cur_ctrl_d;
    logic            pend_shift_q, pend_shift_d, pend_ctrl_q, pend_ctrl_d;
    logic            pend_valid_q, pend_valid_d;
    logic [2:0]      slot_q, slot_d;
    logic [6:0]      md_q, md_d;
    logic            kstrb_q, kstrb_d, akd_q, akd_d, busy_q, busy_d;

    logic            rollover_s, any_down_s, acc_valid_s, in_prev_s;
    logic            hit_s, last_slot_s, strobe_set_s, rep_fire_s;
    logic            in_shift_s, in_ctrl_s, map_valid_s;
    logic [6:0]      map_ascii_s;
    logic [7:0]      slot_code_s;
    logic            unused_mod_bits_s;

    assign in_ctrl_s         = modifiers[0] | modifiers[4];
    assign in_shift_s        = modifiers[1] | modifiers[5];
    assign unused_mod_bits_s = ^{modifiers[7:6], modifiers[3:2]};
    assign slot_code_s       = cur_q[{slot_q, 3'b000} +: 8];
    assign last_slot_s       = (slot_q == LAST_SLOT);

    // Classify the incoming report and look the scanned slot up in the previous report.
    always_comb begin
        rollover_s = 1'b1;
        any_down_s = 1'b0;
        in_prev_s  = 1'b0;
        for (int j = 0; j < NUM_KEYS; j++) begin
            rollover_s = rollover_s & (keycodes[8*j +: 8] == ROLLOVER_CODE);
            any_down_s = any_down_s | (keycodes[8*j +: 8] >= KC_A);
            in_prev_s  = in_prev_s | (prev_q[8*j +: 8] == slot_code_s);
        end
    end

    assign acc_valid_s = report_valid & ~rollover_s;
    assign hit_s       = (state_q == SCAN) && map_valid_s && (slot_code_s >= KC_A) && !in_prev_s;

    ay_kbd_keymap u_keymap (
        .code  (slot_code_s),
        .shift (cur_shift_q),
        .ctrl  (cur_ctrl_q),
        .valid (map_valid_s),
        .ascii (map_ascii_s)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (acc_valid_s || pend_valid_q) begin
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (hit_s || last_slot_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = SCAN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Report capture, pending buffer, slot walk and the strobe/akd outputs.
    always_comb begin
        cur_d        = cur_q;
        cur_shift_d  = cur_shift_q;
        cur_ctrl_d   = cur_ctrl_q;
        prev_d       = prev_q;
        pend_d       = pend_q;
        pend_shift_d = pend_shift_q;
        pend_ctrl_d  = pend_ctrl_q;
        pend_valid_d = pend_valid_q;
        slot_d       = slot_q;
        md_d         = md_q;
        akd_d        = akd_q;
        strobe_set_s = 1'b0;
        if (acc_valid_s) begin
            akd_d = any_down_s;
        end else begin
            akd_d = akd_q;
        end
        if (state_q == IDLE) begin
            slot_d = 3'd0;
            if (acc_valid_s) begin
                cur_d        = keycodes;
                cur_shift_d  = in_shift_s;
                cur_ctrl_d   = in_ctrl_s;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                cur_d        = pend_q;
                cur_shift_d  = pend_shift_q;
                cur_ctrl_d   = pend_ctrl_q;
                pend_valid_d = 1'b0;
            end else begin
                pend_valid_d = pend_valid_q;
            end
        end else begin
            // A report arriving mid-scan waits; a later one replaces it.
            if (acc_valid_s) begin
                pend_d       = keycodes;
                pend_shift_d = in_shift_s;
                pend_ctrl_d  = in_ctrl_s;
                pend_valid_d = 1'b1;
            end else begin
                pend_valid_d = pend_valid_q;
            end
            slot_d = slot_q + 3'd1;
            if (hit_s || last_slot_s) begin
                prev_d = cur_q;
            end else begin
                prev_d = prev_q;
            end
            if (hit_s) begin
                md_d         = map_ascii_s;
                strobe_set_s = 1'b1;
            end else begin
                md_d = md_q;
            end
        end
        if (strobe_set_s || rep_fire_s) begin
            kstrb_d = 1'b1;
        end else if (kstrb_clr) begin
            kstrb_d = 1'b0;
        end else begin
            kstrb_d = kstrb_q;
        end
        busy_d = (state_d == SCAN);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cur_q        <= '0;
            cur_shift_q  <= 1'b0;
            cur_ctrl_q   <= 1'b0;
            prev_q       <= '0;
            pend_q       <= '0;
            pend_shift_q <= 1'b0;
            pend_ctrl_q  <= 1'b0;
            pend_valid_q <= 1'b0;
            slot_q       <= 3'd0;
            md_q         <= 7'h00;
            kstrb_q      <= 1'b0;
            akd_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            cur_q        <= cur_d;
            cur_shift_q  <= cur_shift_d;
            cur_ctrl_q   <= cur_ctrl_d;
            prev_q       <= prev_d;
            pend_q       <= pend_d;
            pend_shift_q <= pend_shift_d;
            pend_ctrl_q  <= pend_ctrl_d;
            pend_valid_q <= pend_valid_d;
            slot_q       <= slot_d;
            md_q         <= md_d;
            kstrb_q      <= kstrb_d;
            akd_q        <= akd_d;
            busy_q       <= busy_d;
        end
    end

`ifdef AY_KBD_REPEAT_EN
    localparam logic [31:0] DELAY_M1  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] PERIOD_M1 = 32'(REPEAT_PERIOD - 1);

    logic        rep_active_q, rep_active_d, rep_first_q, rep_first_d, rep_held_s;
    logic [7:0]  rep_code_q, rep_code_d;
    logic [31:0] rep_cnt_q, rep_cnt_d;

    always_comb begin
        rep_held_s = 1'b0;
        for (int j = 0; j < NUM_KEYS; j++) begin
            rep_held_s = rep_held_s | (keycodes[8*j +: 8] == rep_code_q);
        end
    end

    // A fresh strobe arms the timer; a report without the key disarms it.
    always_comb begin
        rep_active_d = rep_active_q;
        rep_first_d  = rep_first_q;
        rep_code_d   = rep_code_q;
        rep_cnt_d    = rep_cnt_q;
        rep_fire_s   = 1'b0;
        if (hit_s) begin
            rep_active_d = 1'b1;
            rep_first_d  = 1'b1;
            rep_code_d   = slot_code_s;
            rep_cnt_d    = 32'd0;
        end else if (acc_valid_s && !rep_held_s) begin
            rep_active_d = 1'b0;
            rep_cnt_d    = 32'd0;
        end else if (rep_active_q) begin
            if (rep_cnt_q == (rep_first_q ? DELAY_M1 : PERIOD_M1)) begin
                rep_fire_s  = 1'b1;
                rep_first_d = 1'b0;
                rep_cnt_d   = 32'd0;
            end else begin
                rep_cnt_d = rep_cnt_q + 32'd1;
            end
        end else begin
            rep_cnt_d = rep_cnt_q;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rep_active_q <= 1'b0;
            rep_first_q  <= 1'b0;
            rep_code_q   <= 8'h00;
            rep_cnt_q    <= 32'd0;
        end else begin
            rep_active_q <= rep_active_d;
            rep_first_q  <= rep_first_d;
            rep_code_q   <= rep_code_d;
            rep_cnt_q    <= rep_cnt_d;
        end
    end
`else
    assign rep_fire_s = 1'b0;
`endif

    assign md_out = md_q;
    assign kstrb  = kstrb_q;
    assign akd    = akd_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_ay_kbd_encoder.sv
// Directed self-checking bench for ay_kbd_encoder (NUM_KEYS=6, repeat timing 10/4).
module tb_ay_kbd_encoder;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        report_valid = 1'b0;
    logic        kstrb_clr = 1'b0;
    logic [47:0] keycodes = 48'h0;
    logic [7:0]  modifiers = 8'h00;
    logic [6:0]  md_out;
    logic        kstrb, akd, busy;
    int          checks = 0;
    int          errors = 0;
    int          cnt;

    ay_kbd_encoder #(.NUM_KEYS(6), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .report_valid (report_valid),
        .keycodes     (keycodes),
        .modifiers    (modifiers),
        .kstrb_clr    (kstrb_clr),
        .md_out       (md_out),
        .kstrb        (kstrb),
        .akd          (akd),
        .busy         (busy)
    );

    always #5 Clk = ~Clk;

    function automatic logic [47:0] rpt(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2);
        return {24'h0, s2, s1, s0};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [47:0] k, input logic [7:0] m);
        keycodes     = k;
        modifiers    = m;
        report_valid = 1'b1;
        tick();
        report_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("idle_timeout", 32'(busy), 32'h0);
    endtask

    task automatic clr();
        kstrb_clr = 1'b1;
        tick();
        kstrb_clr = 1'b0;
    endtask

    task automatic press(input string tag, input logic [7:0] code, input logic [7:0] m, input logic [6:0] exp);
        send(48'h0, 8'h00);
        wait_idle();
        clr();
        send(rpt(code, 8'h00, 8'h00), m);
        tick();
        chk(tag, 32'(md_out), 32'(exp));
        chk({tag, "_strb"}, 32'(kstrb), 32'h1);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_md", 32'(md_out), 32'h0);
        chk("rst_kstrb", 32'(kstrb), 32'h0);
        chk("rst_akd", 32'(akd), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        Reset = 1'b0;
        tick();

        // Reset in the middle of a scan
        send(rpt(8'h04, 8'h00, 8'h00), 8'h00);
        chk("midscan_akd", 32'(akd), 32'h1);
        chk("midscan_busy", 32'(busy), 32'h1);
        Reset = 1'b1;
        tick();
        chk("midscan_kstrb", 32'(kstrb), 32'h0);
        chk("midscan_md", 32'(md_out), 32'h0);
        chk("midscan_busy0", 32'(busy), 32'h0);
        Reset = 1'b0;
        tick();

        send(rpt(8'h04, 8'h00, 8'h00), 8'h00);
        tick();
        chk("simple_md", 32'(md_out), 32'h41);
        chk("simple_kstrb", 32'(kstrb), 32'h1);
        chk("simple_akd", 32'(akd), 32'h1);
        wait_idle();
        clr();
        chk("clr_kstrb", 32'(kstrb), 32'h0);
        send(rpt(8'h04, 8'h00, 8'h00), 8'h00);
        repeat (7) tick();
        chk("held_kstrb", 32'(kstrb), 32'h0);
        chk("held_md", 32'(md_out), 32'h41);

        press("ctrl_c", 8'h06, 8'h01, 7'h03);
        press("shift_2", 8'h1F, 8'h02, 7'h22);
        press("shift_0", 8'h27, 8'h20, 7'h30);
        press("bksp", 8'h2A, 8'h00, 7'h7F);
        press("shift_z", 8'h1D, 8'h02, 7'h5A);
        press("ctrl_left", 8'h50, 8'h01, 7'h08);

        send(48'h0, 8'h00);
        wait_idle();
        clr();
        send(rpt(8'h3A, 8'h00, 8'h00), 8'h00);
        chk("unmapped_akd", 32'(akd), 32'h1);
        repeat (7) tick();
        chk("unmapped_kstrb", 32'(kstrb), 32'h0);
        chk("unmapped_md", 32'(md_out), 32'h08);

        // Several keys down, only the lowest new slot strobes
        send(48'h0, 8'h00);
        wait_idle();
        send(rpt(8'h04, 8'h00, 8'h00), 8'h00);
        wait_idle();
        clr();
        send(rpt(8'h04, 8'h05, 8'h06), 8'h00);
        chk("multi_t1", 32'(kstrb), 32'h0);
        tick();
        chk("multi_t2", 32'(kstrb), 32'h0);
        tick();
        chk("multi_t3_kstrb", 32'(kstrb), 32'h1);
        chk("multi_t3_md", 32'(md_out), 32'h42);
        chk("multi_t3_busy", 32'(busy), 32'h0);

        clr();
        send(48'h010101010101, 8'h00);
        chk("roll_akd", 32'(akd), 32'h1);
        chk("roll_busy", 32'(busy), 32'h0);
        tick();
        chk("roll_md", 32'(md_out), 32'h42);
        send(rpt(8'h04, 8'h05, 8'h06), 8'h00);
        repeat (8) tick();
        chk("roll_prev_kept", 32'(kstrb), 32'h0);

        // Strobe and clear in the same cycle
        send(48'h0, 8'h00);
        wait_idle();
        clr();
        send(rpt(8'h05, 8'h00, 8'h00), 8'h00);
        kstrb_clr = 1'b1;
        tick();
        kstrb_clr = 1'b0;
        chk("collision_kstrb", 32'(kstrb), 32'h1);
        chk("collision_md", 32'(md_out), 32'h42);

        // Two reports during a busy scan: the later one wins
        send(48'h0, 8'h00);
        wait_idle();
        kstrb_clr = 1'b1;
        cnt = 0;
        send(rpt(8'h3A, 8'h00, 8'h00), 8'h00);
        chk("pend_busy", 32'(busy), 32'h1);
        send(rpt(8'h05, 8'h00, 8'h00), 8'h00);
        send(rpt(8'h06, 8'h00, 8'h00), 8'h00);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (kstrb === 1'b1) cnt++;
        end
        kstrb_clr = 1'b0;
        chk("pend_strobes", 32'(cnt), 32'h1);
        chk("pend_md", 32'(md_out), 32'h43);

`ifdef AY_KBD_REPEAT_EN
        begin
            logic [31:0] mask;
            mask = 32'h0;
            kstrb_clr = 1'b1;
            send(48'h0, 8'h00);
            wait_idle();
            send(rpt(8'h04, 8'h00, 8'h00), 8'h00);
            for (int i = 1; i <= 30; i++) begin
                if (i == 5) begin
                    keycodes     = rpt(8'h04, 8'h00, 8'h00);
                    report_valid = 1'b1;
                end else if (i == 20) begin
                    keycodes     = 48'h0;
                    report_valid = 1'b1;
                end else begin
                    report_valid = 1'b0;
                end
                tick();
                report_valid = 1'b0;
                if (kstrb === 1'b1) mask[i] = 1'b1;
            end
            kstrb_clr = 1'b0;
            chk("repeat_mask", mask, 32'h0008_8802);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
